// File: rtl/ctrl_pipe.sv
// Control-side ID/EX, EX/MEM, MEM/WB registers plus load-use hazard detect.
// Define CTRL_PIPE_STATS_EN to add the saturating stall_cnt_o counter.
module ctrl_pipe #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             wb_i,
    input  logic [1:0]             mem_i,
    input  logic [3:0]             ex_i,
    input  logic [4:0]             rs_i,
    input  logic [4:0]             rt_i,
    input  logic [4:0]             rd_i,
    input  logic                   flush_i,
    output logic                   hd_o,
    output logic                   pc_write_o,
    output logic                   ifid_write_o,
    output logic [3:0]             ex_ctrl_o,
    output logic [1:0]             ex_wb_o,
    output logic [1:0]             ex_mem_o,
    output logic [1:0]             mem_wb_o,
    output logic [1:0]             mem_ctrl_o,
    output logic [1:0]             wb_ctrl_o,
    output logic [4:0]             exmem_rd_o,
    output logic [4:0]             memwb_rd_o,
    output logic                   exmem_regwrite_o,
    output logic                   memwb_regwrite_o
`ifdef CTRL_PIPE_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

    logic [1:0] idex_wb_q, idex_wb_d;
    logic [1:0] idex_mem_q, idex_mem_d;
    logic [3:0] idex_ex_q, idex_ex_d;
    logic [4:0] idex_rt_q, idex_rt_d;
    logic [4:0] idex_rd_q, idex_rd_d;
    logic [1:0] exmem_wb_q, exmem_wb_d;
    logic [1:0] exmem_mem_q, exmem_mem_d;
    logic [4:0] exmem_rd_q, exmem_rd_d;
    logic [1:0] memwb_wb_q, memwb_wb_d;
    logic [4:0] memwb_rd_q, memwb_rd_d;
    logic       hd;

    // A taken branch squashes the dependent instruction, so no stall is needed.
    assign hd = idex_mem_q[1] & ~flush_i & (idex_rt_q != 5'd0)
              & ((idex_rt_q == rs_i) | (idex_rt_q == rt_i));

    always_comb begin
        idex_wb_d  = wb_i;
        idex_mem_d = mem_i;
        idex_ex_d  = ex_i;
        idex_rt_d  = rt_i;
        idex_rd_d  = rd_i;
        if (flush_i || hd) begin
            idex_wb_d  = 2'd0;
            idex_mem_d = 2'd0;
            idex_ex_d  = 4'd0;
        end
        exmem_wb_d  = idex_wb_q;
        exmem_mem_d = idex_mem_q;
        exmem_rd_d  = idex_ex_q[3] ? idex_rd_q : idex_rt_q;
        memwb_wb_d  = exmem_wb_q;
        memwb_rd_d  = exmem_rd_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idex_wb_q   <= 2'd0;
            idex_mem_q  <= 2'd0;
            idex_ex_q   <= 4'd0;
            idex_rt_q   <= 5'd0;
            idex_rd_q   <= 5'd0;
            exmem_wb_q  <= 2'd0;
            exmem_mem_q <= 2'd0;
            exmem_rd_q  <= 5'd0;
            memwb_wb_q  <= 2'd0;
            memwb_rd_q  <= 5'd0;
        end else begin
            idex_wb_q   <= idex_wb_d;
            idex_mem_q  <= idex_mem_d;
            idex_ex_q   <= idex_ex_d;
            idex_rt_q   <= idex_rt_d;
            idex_rd_q   <= idex_rd_d;
            exmem_wb_q  <= exmem_wb_d;
            exmem_mem_q <= exmem_mem_d;
            exmem_rd_q  <= exmem_rd_d;
            memwb_wb_q  <= memwb_wb_d;
            memwb_rd_q  <= memwb_rd_d;
        end
    end

    assign hd_o             = hd;
    assign pc_write_o       = ~hd;
    assign ifid_write_o     = ~hd;
    assign ex_ctrl_o        = idex_ex_q;
    assign ex_wb_o          = idex_wb_q;
    assign ex_mem_o         = idex_mem_q;
    assign mem_wb_o         = exmem_wb_q;
    assign mem_ctrl_o       = exmem_mem_q;
    assign wb_ctrl_o        = memwb_wb_q;
    assign exmem_rd_o       = exmem_rd_q;
    assign memwb_rd_o       = memwb_rd_q;
    assign exmem_regwrite_o = exmem_wb_q[1];
    assign memwb_regwrite_o = memwb_wb_q[1];

`ifdef CTRL_PIPE_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hd && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed table-driven bench for ctrl_pipe, plus reset and stats sequences.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] wb, mem;
    logic [3:0] ex;
    logic [4:0] rs, rt, rd;
    logic       flush;
    logic       hd_o, pc_write_o, ifid_write_o;
    logic [3:0] ex_ctrl_o;
    logic [1:0] ex_wb_o, ex_mem_o, mem_wb_o, mem_ctrl_o, wb_ctrl_o;
    logic [4:0] exmem_rd_o, memwb_rd_o;
    logic       exmem_regwrite_o, memwb_regwrite_o;
`ifdef CTRL_PIPE_STATS_EN
    logic [1:0] stall_cnt_o;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.STALL_CNT_W(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .wb_i             (wb),
        .mem_i            (mem),
        .ex_i             (ex),
        .rs_i             (rs),
        .rt_i             (rt),
        .rd_i             (rd),
        .flush_i          (flush),
        .hd_o             (hd_o),
        .pc_write_o       (pc_write_o),
        .ifid_write_o     (ifid_write_o),
        .ex_ctrl_o        (ex_ctrl_o),
        .ex_wb_o          (ex_wb_o),
        .ex_mem_o         (ex_mem_o),
        .mem_wb_o         (mem_wb_o),
        .mem_ctrl_o       (mem_ctrl_o),
        .wb_ctrl_o        (wb_ctrl_o),
        .exmem_rd_o       (exmem_rd_o),
        .memwb_rd_o       (memwb_rd_o),
        .exmem_regwrite_o (exmem_regwrite_o),
        .memwb_regwrite_o (memwb_regwrite_o)
`ifdef CTRL_PIPE_STATS_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    typedef struct {
        logic       flush;
        logic [1:0] wb;
        logic [1:0] mem;
        logic [3:0] ex;
        logic [4:0] rs, rt, rd;
        logic       hd;
        logic [3:0] e_ex;
        logic [1:0] e_exwb, e_exmem, e_memwb, e_memctl, e_wbctl;
        logic [4:0] e_exrd, e_mwrd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic f, input logic [1:0] w, input logic [1:0] m,
        input logic [3:0] e, input logic [4:0] s, input logic [4:0] t,
        input logic [4:0] d, input logic h, input logic [3:0] xe,
        input logic [1:0] xw, input logic [1:0] xm, input logic [1:0] mw,
        input logic [1:0] mc, input logic [1:0] wc, input logic [4:0] xr,
        input logic [4:0] mr);
        vec_t v;
        v.flush = f; v.wb = w; v.mem = m; v.ex = e;
        v.rs = s; v.rt = t; v.rd = d; v.hd = h;
        v.e_ex = xe; v.e_exwb = xw; v.e_exmem = xm;
        v.e_memwb = mw; v.e_memctl = mc; v.e_wbctl = wc;
        v.e_exrd = xr; v.e_mwrd = mr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic set_in(input logic r, input logic f, input logic [1:0] w,
                          input logic [1:0] m, input logic [3:0] e,
                          input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d);
        rst = r; flush = f; wb = w; mem = m; ex = e; rs = s; rt = t; rd = d;
    endtask

    initial begin
        // flush wb mem ex rs rt rd | hd ex exwb exmem memwb memctl wbctl exrd mwrd
        vq.push_back(mk(0,2,0,4'hC,1,2,5,   0,0,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,4'hC,2,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,2,0,0,5,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,2,0,5));
        vq.push_back(mk(0,2,0,4'h2,3,9,7,   0,0,0,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,2,2,0,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,2,0,0,9,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,2,0,9));
        // load-use
        vq.push_back(mk(0,3,2,1,2,8,0,      0,0,0,0,0,0,0,0,0));
        vq.push_back(mk(0,2,0,4'hC,8,4,6,   1,1,3,2,0,0,0,0,0));
        vq.push_back(mk(0,2,0,4'hC,8,4,6,   0,0,0,0,3,2,0,8,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,4'hC,2,0,0,0,3,4,8));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,2,0,0,6,4));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,2,0,6));
        // register zero never stalls
        vq.push_back(mk(0,3,2,1,0,0,0,      0,0,0,0,0,0,0,0,0));
        vq.push_back(mk(0,2,0,4'hC,0,0,3,   0,1,3,2,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,4'hC,2,0,3,2,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,2,0,3,3,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,2,0,3));
        // flush beats hazard
        vq.push_back(mk(0,3,2,1,0,10,0,     0,0,0,0,0,0,0,0,0));
        vq.push_back(mk(1,2,0,4'h8,1,10,11, 0,1,3,2,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,3,2,0,10,0));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,3,10,10));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0,10));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0,0));
        // back-to-back dependent loads
        vq.push_back(mk(0,3,2,1,0,5,0,      0,0,0,0,0,0,0,0,0));
        vq.push_back(mk(0,3,2,1,5,6,0,      1,1,3,2,0,0,0,0,0));
        vq.push_back(mk(0,3,2,1,5,6,0,      0,0,0,0,3,2,0,5,0));
        vq.push_back(mk(0,2,0,4'hC,0,6,7,   1,1,3,2,0,0,3,6,5));
        vq.push_back(mk(0,2,0,4'hC,0,6,7,   0,0,0,0,3,2,0,6,6));
        vq.push_back(mk(0,0,0,0,0,0,0,      0,4'hC,2,0,0,0,3,6,6));

        // reset with nonzero inputs
        set_in(1, 0, 2'd3, 2'd3, 4'hF, 5'd1, 5'd1, 5'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst hd", int'(hd_o), 0);
        chk("rst pc_write", int'(pc_write_o), 1);
        chk("rst ifid_write", int'(ifid_write_o), 1);
        chk("rst ex_ctrl", int'(ex_ctrl_o), 0);
        chk("rst ex_wb", int'(ex_wb_o), 0);
        chk("rst ex_mem", int'(ex_mem_o), 0);
        chk("rst mem_wb", int'(mem_wb_o), 0);
        chk("rst mem_ctrl", int'(mem_ctrl_o), 0);
        chk("rst wb_ctrl", int'(wb_ctrl_o), 0);
        chk("rst exmem_rd", int'(exmem_rd_o), 0);
        chk("rst memwb_rd", int'(memwb_rd_o), 0);
        chk("rst exmem_rw", int'(exmem_regwrite_o), 0);
        chk("rst memwb_rw", int'(memwb_regwrite_o), 0);

        for (int i = 0; i < vq.size(); i++) begin
            if (i > 0) @(negedge clk);
            set_in(0, vq[i].flush, vq[i].wb, vq[i].mem, vq[i].ex,
                   vq[i].rs, vq[i].rt, vq[i].rd);
            #1;
            chk($sformatf("v%0d hd", i), int'(hd_o), int'(vq[i].hd));
            chk($sformatf("v%0d pc_write", i), int'(pc_write_o), int'(!vq[i].hd));
            chk($sformatf("v%0d ifid_write", i), int'(ifid_write_o), int'(!vq[i].hd));
            chk($sformatf("v%0d ex_ctrl", i), int'(ex_ctrl_o), int'(vq[i].e_ex));
            chk($sformatf("v%0d ex_wb", i), int'(ex_wb_o), int'(vq[i].e_exwb));
            chk($sformatf("v%0d ex_mem", i), int'(ex_mem_o), int'(vq[i].e_exmem));
            chk($sformatf("v%0d mem_wb", i), int'(mem_wb_o), int'(vq[i].e_memwb));
            chk($sformatf("v%0d mem_ctrl", i), int'(mem_ctrl_o), int'(vq[i].e_memctl));
            chk($sformatf("v%0d wb_ctrl", i), int'(wb_ctrl_o), int'(vq[i].e_wbctl));
            chk($sformatf("v%0d exmem_rd", i), int'(exmem_rd_o), int'(vq[i].e_exrd));
            chk($sformatf("v%0d memwb_rd", i), int'(memwb_rd_o), int'(vq[i].e_mwrd));
            chk($sformatf("v%0d exmem_rw", i), int'(exmem_regwrite_o),
                int'(vq[i].e_memwb[1]));
            chk($sformatf("v%0d memwb_rw", i), int'(memwb_regwrite_o),
                int'(vq[i].e_wbctl[1]));
        end

        // reset in the middle of a stall
        @(negedge clk);
        set_in(0, 0, 2'd3, 2'd2, 4'h1, 5'd0, 5'd12, 5'd0);
        @(negedge clk);
        set_in(1, 0, 2'd2, 2'd0, 4'hC, 5'd12, 5'd0, 5'd1);
        #1;
        chk("midrst hd before edge", int'(hd_o), 1);
        chk("midrst pc_write before edge", int'(pc_write_o), 0);
        @(negedge clk);
        #1;
        chk("midrst hd after edge", int'(hd_o), 0);
        chk("midrst pc_write after edge", int'(pc_write_o), 1);
        chk("midrst ex_ctrl", int'(ex_ctrl_o), 0);
        chk("midrst ex_mem", int'(ex_mem_o), 0);
        chk("midrst exmem_rd", int'(exmem_rd_o), 0);
        chk("midrst memwb_rd", int'(memwb_rd_o), 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

`ifdef CTRL_PIPE_STATS_EN
        begin
            int exp_cnt[5] = '{1, 2, 3, 3, 3};
            @(negedge clk);
            #1;
            chk("stats after reset", int'(stall_cnt_o), 0);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                set_in(0, 0, 2'd3, 2'd2, 4'h1, 5'd0, 5'd8, 5'd0);
                @(negedge clk);
                set_in(0, 0, 2'd2, 2'd0, 4'hC, 5'd8, 5'd0, 5'd1);
                #1;
                chk($sformatf("stats%0d hd", k), int'(hd_o), 1);
                @(negedge clk);
                set_in(0, 0, 0, 0, 0, 0, 0, 0);
                #1;
                chk($sformatf("stats%0d cnt", k), int'(stall_cnt_o), exp_cnt[k]);
            end
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("stats cleared", int'(stall_cnt_o), 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
